// File: rtl/mem2_load_resp_stage_pkg.sv
// rtl/mem2_load_resp_stage_pkg.sv - shared load types, writeback selects and MEM2 FSM states
package mem2_load_resp_stage_pkg;

    typedef enum logic [2:0] {
        LT_LB  = 3'd0,
        LT_LBU = 3'd1,
        LT_LH  = 3'd2,
        LT_LHU = 3'd3,
        LT_LW  = 3'd4,
        LT_LWL = 3'd5,
        LT_LWR = 3'd6
    } load_type_e;

    localparam logic [1:0] WB_PC8  = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_OUTB = 2'd2;
    localparam logic [1:0] WB_LOAD = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem2_resp_fifo.sv
// rtl/mem2_resp_fifo.sv - in-order dcache load-response FIFO with wrap-bit pointers
module mem2_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [XLEN-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; flush empties the queue regardless of push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, no reset needed since empty gates every read
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Upstream issue throttling must keep the queue from overflowing
    a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/mem2_load_resp_stage.sv
// rtl/mem2_load_resp_stage.sv - MEM2 pipeline stage with load-response buffer; optional MEM2_LWLR_EN merges LWL/LWR
module mem2_load_resp_stage #(
    parameter int XLEN       = 32,
    parameter int RESP_DEPTH = 2,
    parameter int MAX_OUTST  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem2_flush,
    input  logic            mem2_wr,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_aluout,
    input  logic [XLEN-1:0] in_outb,
    input  logic [4:0]      in_dst,
    input  logic [1:0]      in_wbsel,
    input  logic            in_regwr,
    input  logic [2:0]      in_loadtype,
    input  logic            dc_req_fire,
    input  logic            dc_rvalid,
    input  logic [XLEN-1:0] dc_rdata,
    output logic            mem2_valid,
    output logic [XLEN-1:0] mem2_pc,
    output logic [4:0]      mem2_dst,
    output logic            mem2_regwr,
    output logic [XLEN-1:0] mem2_result,
    output logic            mem2_res_rdy,
    output logic            mem2_stall_req,
    output logic            dc_req_ok
);

    import mem2_load_resp_stage_pkg::*;

    localparam int CW = $clog2(MAX_OUTST + 1);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] aluout_q;
    logic [XLEN-1:0] outb_q;
    logic [4:0]      dst_q;
    logic [1:0]      wbsel_q;
    logic            regwr_q;
    logic [2:0]      loadtype_q;
    logic [1:0]      state_q;
    logic [XLEN-1:0] hold_q;
    logic [CW-1:0]   outst_cnt;
    logic [CW-1:0]   drop_cnt;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [XLEN-1:0] fifo_head;

    logic            is_load;
    logic            rsp_acc;
    logic            head_avail;
    logic            consume;
    logic [XLEN-1:0] word_sel;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] ld_data;

    // A response only belongs to a live load once all squashed loads have drained
    assign is_load    = valid_q && (wbsel_q == WB_LOAD);
    assign rsp_acc    = dc_rvalid && (drop_cnt == '0) && !mem2_flush;
    assign head_avail = !fifo_empty || rsp_acc;
    assign consume    = is_load && (state_q != ST_DONE) && head_avail && !mem2_flush;
    assign fifo_pop   = consume && !fifo_empty;
    assign fifo_push  = rsp_acc && !(consume && fifo_empty);
    assign word_sel   = (state_q == ST_DONE) ? hold_q : (fifo_empty ? dc_rdata : fifo_head);

    assign mem2_valid     = valid_q;
    assign mem2_pc        = pc_q;
    assign mem2_dst       = dst_q;
    assign mem2_regwr     = valid_q && regwr_q;
    assign mem2_res_rdy   = !is_load || (state_q == ST_DONE) || head_avail;
    assign mem2_stall_req = is_load && !mem2_res_rdy;
    assign dc_req_ok      = (outst_cnt < CW'(MAX_OUTST)) && !fifo_full;

    mem2_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (mem2_flush),
        .push      (fifo_push),
        .push_data (dc_rdata),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // MEM->MEM2 register; flush beats advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            aluout_q   <= '0;
            outb_q     <= '0;
            dst_q      <= '0;
            wbsel_q    <= '0;
            regwr_q    <= 1'b0;
            loadtype_q <= '0;
        end else if (mem2_flush) begin
            valid_q <= 1'b0;
        end else if (mem2_wr) begin
            valid_q    <= in_valid;
            pc_q       <= in_pc;
            aluout_q   <= in_aluout;
            outb_q     <= in_outb;
            dst_q      <= in_dst;
            wbsel_q    <= in_wbsel;
            regwr_q    <= in_regwr;
            loadtype_q <= in_loadtype;
        end
    end

    // Loads in flight; simultaneous issue and return cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_cnt <= '0;
        end else if (dc_req_fire && !dc_rvalid) begin
            if (outst_cnt != CW'(MAX_OUTST)) outst_cnt <= outst_cnt + 1'b1;
        end else if (!dc_req_fire && dc_rvalid && (outst_cnt != '0)) begin
            outst_cnt <= outst_cnt - 1'b1;
        end
    end

    // Responses still owed to squashed loads, including one issued during the flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (mem2_flush) begin
            drop_cnt <= outst_cnt - CW'(dc_rvalid) + CW'(dc_req_fire);
        end else if (dc_rvalid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // Load wait/done tracking; the consumed word is frozen in hold_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else if (mem2_flush) begin
            state_q <= ST_IDLE;
        end else if (state_q == ST_DONE) begin
            if (mem2_wr) state_q <= ST_IDLE;
        end else if (consume) begin
            hold_q  <= word_sel;
            state_q <= mem2_wr ? ST_IDLE : ST_DONE;
        end else if (is_load && !mem2_wr) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= ST_IDLE;
        end
    end

    // Byte/halfword select and extension by load type
    always_comb begin
        byte_v = word_sel[{aluout_q[1:0], 3'b000} +: 8];
        half_v = aluout_q[1] ? word_sel[31:16] : word_sel[15:0];
        case (loadtype_q)
            LT_LB:   ld_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            LT_LBU:  ld_data = {{(XLEN-8){1'b0}}, byte_v};
            LT_LH:   ld_data = {{(XLEN-16){half_v[15]}}, half_v};
            LT_LHU:  ld_data = {{(XLEN-16){1'b0}}, half_v};
            default: ld_data = word_sel;
        endcase
`ifdef MEM2_LWLR_EN
        if (loadtype_q == LT_LWL) begin
            case (aluout_q[1:0])
                2'd0:    ld_data = {word_sel[7:0],  outb_q[23:0]};
                2'd1:    ld_data = {word_sel[15:0], outb_q[15:0]};
                2'd2:    ld_data = {word_sel[23:0], outb_q[7:0]};
                default: ld_data = word_sel;
            endcase
        end else if (loadtype_q == LT_LWR) begin
            case (aluout_q[1:0])
                2'd1:    ld_data = {outb_q[31:24], word_sel[31:8]};
                2'd2:    ld_data = {outb_q[31:16], word_sel[31:16]};
                2'd3:    ld_data = {outb_q[31:8],  word_sel[31:24]};
                default: ld_data = word_sel;
            endcase
        end
`endif
    end

    // Writeback value selection
    always_comb begin
        case (wbsel_q)
            WB_PC8:  mem2_result = pc_q + XLEN'(8);
            WB_ALU:  mem2_result = aluout_q;
            WB_OUTB: mem2_result = outb_q;
            default: mem2_result = ld_data;
        endcase
    end

endmodule

// File: tb/tb_mem2_load_resp_stage.sv
// tb/tb_mem2_load_resp_stage.sv - randomized self-checking bench for mem2_load_resp_stage
module tb_mem2_load_resp_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem2_flush, mem2_wr, in_valid, in_regwr;
    logic [31:0] in_pc, in_aluout, in_outb;
    logic [4:0]  in_dst;
    logic [1:0]  in_wbsel;
    logic [2:0]  in_loadtype;
    logic        dc_req_fire, dc_rvalid;
    logic [31:0] dc_rdata;
    logic        mem2_valid, mem2_regwr, mem2_res_rdy, mem2_stall_req, dc_req_ok;
    logic [31:0] mem2_pc, mem2_result;
    logic [4:0]  mem2_dst;

    int checks = 0;
    int errors = 0;

    mem2_load_resp_stage #(.XLEN(32), .RESP_DEPTH(2), .MAX_OUTST(4)) dut (
        .clk(clk), .rst(rst), .mem2_flush(mem2_flush), .mem2_wr(mem2_wr),
        .in_valid(in_valid), .in_pc(in_pc), .in_aluout(in_aluout), .in_outb(in_outb),
        .in_dst(in_dst), .in_wbsel(in_wbsel), .in_regwr(in_regwr), .in_loadtype(in_loadtype),
        .dc_req_fire(dc_req_fire), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .mem2_valid(mem2_valid), .mem2_pc(mem2_pc), .mem2_dst(mem2_dst), .mem2_regwr(mem2_regwr),
        .mem2_result(mem2_result), .mem2_res_rdy(mem2_res_rdy), .mem2_stall_req(mem2_stall_req),
        .dc_req_ok(dc_req_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Architectural load value from MIPS little-endian rules
    function automatic logic [31:0] model_load(input int lt, input int a, input logic [31:0] w,
                                               input logic [31:0] rt);
        logic [31:0] b, h, m;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (lt)
            0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            1: return b;
            2: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3: return h;
`ifdef MEM2_LWLR_EN
            5: begin
                m = (32'h1 << (8 * (3 - a))) - 32'h1;
                return (w << (8 * (3 - a))) | (rt & m);
            end
            6: begin
                m = 32'hFFFF_FFFF >> (8 * a);
                return (w >> (8 * a)) | (rt & ~m);
            end
`endif
            default: return w;
        endcase
    endfunction

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        mem2_wr = 1'b0; mem2_flush = 1'b0; dc_req_fire = 1'b0; dc_rvalid = 1'b0;
        dc_rdata = $urandom;
    endtask

    task automatic enter(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] outb,
                         input logic [4:0] dst, input logic [1:0] wb, input logic rw,
                         input logic [2:0] lt, input logic fire);
        in_valid = 1'b1; in_pc = pc; in_aluout = alu; in_outb = outb; in_dst = dst;
        in_wbsel = wb; in_regwr = rw; in_loadtype = lt; mem2_wr = 1'b1; dc_req_fire = fire;
        cyc();
    endtask

    initial begin
        int n;
        logic [31:0] w, pc, alu, outb, expv;
        int lt, d, pre, h;
        logic [1:0] wb;
        logic is_ld, early;
        logic [4:0] dst;
        logic rw;

        rst = 1'b1; mem2_flush = 0; mem2_wr = 0; in_valid = 0; in_pc = 0; in_aluout = 0;
        in_outb = 0; in_dst = 0; in_wbsel = 0; in_regwr = 0; in_loadtype = 0;
        dc_req_fire = 0; dc_rvalid = 0; dc_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        check("rst_valid", mem2_valid, 0);
        check("rst_pc", mem2_pc, 0);
        check("rst_dst", mem2_dst, 0);
        check("rst_regwr", mem2_regwr, 0);
        check("rst_rdy", mem2_res_rdy, 1);
        check("rst_stall", mem2_stall_req, 0);
        check("rst_req_ok", dc_req_ok, 1);
        cyc();

        // LB late by one cycle -> one WAIT cycle
        enter(32'h100, 32'h1003, 32'h0, 5'd5, 2'd3, 1'b1, 3'd0, 1'b1);
        settle();
        check("lb_stall_entry", mem2_stall_req, 1);
        check("lb_rdy_entry", mem2_res_rdy, 0);
        cyc();
        dc_rvalid = 1'b1; dc_rdata = 32'h80FF_1234;
        settle();
        check("lb_rdy", mem2_res_rdy, 1);
        check("lb_stall", mem2_stall_req, 0);
        check("lb_result", mem2_result, 32'hFFFF_FF80);
        check("lb_pc", mem2_pc, 32'h100);
        check("lb_dst", mem2_dst, 5'd5);
        check("lb_regwr", mem2_regwr, 1);
        cyc();

        // Hold 5 cycles in DONE while the next load's response arrives early
        for (int i = 0; i < 5; i++) begin
            if (i == 0) dc_req_fire = 1'b1;
            if (i == 3) begin dc_rvalid = 1'b1; dc_rdata = 32'hDEAD_BEEF; end
            settle();
            check("hold_result", mem2_result, 32'hFFFF_FF80);
            check("hold_rdy", mem2_res_rdy, 1);
            cyc();
        end
        check("hold_req_ok", dc_req_ok, 1);
        enter(32'h104, 32'h2, 32'h0, 5'd6, 2'd3, 1'b1, 3'd3, 1'b0);
        settle();
        check("early_rdy", mem2_res_rdy, 1);
        check("early_stall", mem2_stall_req, 0);
        check("early_result", mem2_result, 32'h0000_DEAD);
        cyc();
        settle();
        check("early_held", mem2_result, 32'h0000_DEAD);

        // Flush with two loads outstanding; two responses dropped
        dc_req_fire = 1'b1; cyc();
        dc_req_fire = 1'b1; cyc();
        mem2_flush = 1'b1; mem2_wr = 1'b1; in_valid = 1'b1; cyc();
        settle();
        check("flush_valid", mem2_valid, 0);
        check("flush_regwr", mem2_regwr, 0);
        enter(32'h200, 32'h3000, 32'h0, 5'd7, 2'd3, 1'b1, 3'd4, 1'b1);
        for (int i = 0; i < 2; i++) begin
            dc_rvalid = 1'b1; dc_rdata = 32'hBAD0_0000 + i;
            settle();
            check("drop_stall", mem2_stall_req, 1);
            cyc();
        end
        dc_rvalid = 1'b1; dc_rdata = 32'h1234_5678;
        settle();
        check("drop_rdy", mem2_res_rdy, 1);
        check("drop_result", mem2_result, 32'h1234_5678);
        cyc();

        // Back-pressure: issue until refused
        n = 0;
        while (dc_req_ok && n < 8) begin
            dc_req_fire = 1'b1; cyc(); n++;
        end
        check("bp_issued", n, 4);
        dc_req_fire = 1'b1; dc_rvalid = 1'b1; cyc();
        check("bp_fire_rvalid_ok", dc_req_ok, 0);
        mem2_flush = 1'b1; cyc();
        for (int i = 0; i < 4; i++) begin
            dc_rvalid = 1'b1; cyc();
        end
        check("bp_drain_ok", dc_req_ok, 1);
        enter(32'h300, 32'h0, 32'h0, 5'd8, 2'd3, 1'b1, 3'd4, 1'b1);
        dc_rvalid = 1'b1; dc_rdata = 32'hCAFE_F00D;
        settle();
        check("bp_bypass_rdy", mem2_res_rdy, 1);
        check("bp_bypass_result", mem2_result, 32'hCAFE_F00D);
        cyc();

        // LWL merge (or plain word without the merge feature)
        enter(32'h400, 32'h4001, 32'h1122_3344, 5'd9, 2'd3, 1'b1, 3'd5, 1'b1);
        dc_rvalid = 1'b1; dc_rdata = 32'hAABB_CCDD;
        settle();
`ifdef MEM2_LWLR_EN
        check("lwl_result", mem2_result, 32'hCCDD_3344);
`else
        check("lwl_result", mem2_result, 32'hAABB_CCDD);
`endif
        cyc();

        // Non-load selects, PC+8 wrap
        enter(32'hFFFF_FFFC, 32'h55, 32'h66, 5'd1, 2'd0, 1'b1, 3'd0, 1'b0);
        settle();
        check("pc8_wrap", mem2_result, 32'h4);
        check("pc8_rdy", mem2_res_rdy, 1);
        enter(32'h10, 32'h55, 32'h66, 5'd1, 2'd1, 1'b0, 3'd0, 1'b0);
        settle();
        check("alu_sel", mem2_result, 32'h55);
        check("regwr_low", mem2_regwr, 0);
        enter(32'h10, 32'h55, 32'h66, 5'd1, 2'd2, 1'b1, 3'd0, 1'b0);
        settle();
        check("outb_sel", mem2_result, 32'h66);

        // Randomized instruction stream with early/late responses and holds
        for (int it = 0; it < 200; it++) begin
            is_ld = ($urandom_range(0, 2) != 0);
            wb    = is_ld ? 2'd3 : 2'($urandom_range(0, 2));
            lt    = $urandom_range(0, 6);
            pc    = $urandom; alu = $urandom; outb = $urandom; w = $urandom;
            dst   = 5'($urandom); rw = 1'($urandom);
            early = is_ld && ($urandom_range(0, 1) == 1);
            pre   = early ? $urandom_range(1, 2) : $urandom_range(0, 1);
            case (wb)
                2'd0:    expv = pc + 32'd8;
                2'd1:    expv = alu;
                2'd2:    expv = outb;
                default: expv = model_load(lt, int'(alu % 4), w, outb);
            endcase
            if (is_ld) begin dc_req_fire = 1'b1; cyc(); end
            for (int p = 0; p < pre; p++) begin
                if (early && p == pre - 1) begin dc_rvalid = 1'b1; dc_rdata = w; end
                cyc();
            end
            enter(pc, alu, outb, dst, wb, rw, 3'(lt), 1'b0);
            if (is_ld && !early) begin
                d = $urandom_range(0, 2);
                for (int k = 0; k < d; k++) begin
                    settle();
                    check("rnd_wait_stall", mem2_stall_req, 1);
                    cyc();
                end
                dc_rvalid = 1'b1; dc_rdata = w;
            end
            settle();
            check("rnd_rdy", mem2_res_rdy, 1);
            check("rnd_stall", mem2_stall_req, 0);
            check("rnd_result", mem2_result, expv);
            check("rnd_pc", mem2_pc, pc);
            check("rnd_dst", mem2_dst, dst);
            check("rnd_regwr", mem2_regwr, rw);
            cyc();
            h = $urandom_range(0, 2);
            for (int k = 0; k < h; k++) begin
                settle();
                check("rnd_hold", mem2_result, expv);
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
